// File: rtl/multicycle_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
// Bundle of the control signals that run between the multicycle RV32I main
// controller and the datapath / unified memory port.
//
// Signals:
//   op[6:0]        opcode field of the instruction register (to controller)
//   mem_ready      memory accepted/completed the current request (to controller)
//   mem_req        memory request valid
//   MemWrite       store request, qualifies mem_req
//   AdrSrc         0 = PC address, 1 = ALU result register address
//   IRWrite        load instruction register
//   PCUpdate       unconditional PC write
//   Branch         PC write qualified by ALU zero
//   RegWrite       register file write enable
//   ALUSrcA[1:0]   00 PC, 01 OldPC, 10 rs1 data
//   ALUSrcB[1:0]   00 rs2 data, 01 immediate, 10 constant 4
//   ALUOp[1:0]     00 add, 01 sub, 10 funct-decoded
//   ResultSrc[1:0] 00 ALUOut, 01 memory data, 10 ALU result
//   fault          sticky illegal-opcode / memory-timeout flag
//   state_o[3:0]   current controller state (debug)
//
// Modports:
//   master - the controller (drives the control outputs)
//   slave  - the datapath/memory side (drives op and mem_ready)
// ---------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
    logic [6:0] op;
    logic       mem_ready;
    logic       mem_req;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCUpdate;
    logic       Branch;
    logic       RegWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ResultSrc;
    logic       fault;
    logic [3:0] state_o;

    modport master (
        input  op, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, fault, state_o
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, fault, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Main control state machine of the multicycle RV32I core. Sequences the
// shared ALU, instruction register, PC and unified memory port through
// fetch / decode / execute / memory / writeback cycles. Memory accesses use a
// req/ready handshake guarded by a bounded wait timeout.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles to wait for mem_ready before faulting (0 = off)
//   CNT_W           width of the performance counters (PERF_CNT_EN only)
//
// Ports:
//   clk        core clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        multicycle_ctrl_fsm_if.master control bundle
//   cycle_cnt  cycles spent outside HALT        (PERF_CNT_EN only)
//   instret_cnt retired instructions            (PERF_CNT_EN only)
//
// Build option:
//   PERF_CNT_EN  when defined, adds the cycle_cnt / instret_cnt counters.
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 255
`ifdef PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_ctrl_fsm_if.master bus
`ifdef PERF_CNT_EN
    , output logic [CNT_W-1:0] cycle_cnt
    , output logic [CNT_W-1:0] instret_cnt
`endif
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_JAL      = 4'd10,
        ST_HALT     = 4'd15
    } state_t;

    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       adrSrc;
        logic       pcUpdate;
        logic       branch;
        logic       regWrite;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] resultSrc;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // The wait counter only has to reach TIMEOUT_CYCLES-1: the cycle that
    // would make it TIMEOUT_CYCLES is the one that raises the fault.
    localparam bit              TIMEOUT_ON = (TIMEOUT_CYCLES != 0);
    localparam int              WAIT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    // Moore control word for each state. Selects that a state does not use
    // sit at the fetch defaults so the datapath sees a quiet, known pattern.
    function automatic ctrl_t decodeState(input state_t s);
        ctrl_t c;
        c           = '0;
        c.aluSrcB   = 2'b10;
        c.resultSrc = 2'b10;
        case (s)
            ST_FETCH:    c.memReq = 1'b1;
            ST_DECODE:   begin c.aluSrcA = 2'b01; c.aluSrcB = 2'b01; end
            ST_MEMADR:   begin c.aluSrcA = 2'b10; c.aluSrcB = 2'b01; end
            ST_MEMREAD:  begin c.memReq = 1'b1; c.adrSrc = 1'b1; end
            ST_MEMWB:    begin c.resultSrc = 2'b01; c.regWrite = 1'b1; end
            ST_MEMWRITE: begin c.memReq = 1'b1; c.memWrite = 1'b1; c.adrSrc = 1'b1; end
            ST_EXECR:    begin c.aluSrcA = 2'b10; c.aluSrcB = 2'b00; c.aluOp = 2'b10; end
            ST_EXECI:    begin c.aluSrcA = 2'b10; c.aluSrcB = 2'b01; c.aluOp = 2'b10; end
            ST_ALUWB:    begin c.resultSrc = 2'b00; c.regWrite = 1'b1; end
            ST_BEQ:      begin
                c.aluSrcA   = 2'b10;
                c.aluSrcB   = 2'b00;
                c.aluOp     = 2'b01;
                c.resultSrc = 2'b00;
                c.branch    = 1'b1;
            end
            ST_JAL:      begin
                c.aluSrcA   = 2'b01;
                c.aluSrcB   = 2'b10;
                c.resultSrc = 2'b00;
                c.pcUpdate  = 1'b1;
            end
            default:     ;
        endcase
        return c;
    endfunction

    // Next-state rules. A timeout overrides whatever the handshake state
    // would otherwise do; unknown encodings fall into HALT.
    function automatic state_t nextState(input state_t s, input logic [6:0] opc,
                                         input logic rdy, input logic tmo);
        state_t n;
        n = s;
        case (s)
            ST_FETCH:    n = rdy ? ST_DECODE : ST_FETCH;
            ST_DECODE:   begin
                case (opc)
                    OP_LOAD, OP_STORE: n = ST_MEMADR;
                    OP_RTYPE:          n = ST_EXECR;
                    OP_ITYPE:          n = ST_EXECI;
                    OP_BRANCH:         n = ST_BEQ;
                    OP_JAL:            n = ST_JAL;
                    default:           n = ST_HALT;
                endcase
            end
            ST_MEMADR:   n = (opc == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  n = rdy ? ST_MEMWB : ST_MEMREAD;
            ST_MEMWB:    n = ST_FETCH;
            ST_MEMWRITE: n = rdy ? ST_FETCH : ST_MEMWRITE;
            ST_EXECR:    n = ST_ALUWB;
            ST_EXECI:    n = ST_ALUWB;
            ST_ALUWB:    n = ST_FETCH;
            ST_BEQ:      n = ST_FETCH;
            ST_JAL:      n = ST_ALUWB;
            ST_HALT:     n = ST_HALT;
            default:     n = ST_HALT;
        endcase
        if (tmo) n = ST_HALT;
        return n;
    endfunction

    state_t              r_state;
    ctrl_t               r_ctrl;
    logic                r_fault;
    logic [WAIT_W-1:0]   r_waitCnt;

    logic                w_timeout;
    logic                w_setFault;
    logic                w_fetchDone;
    state_t              w_nextState;

    // mem_ready in the limit cycle wins because it is excluded here.
    assign w_timeout   = TIMEOUT_ON && r_ctrl.memReq && !bus.mem_ready && (r_waitCnt == WAIT_LIMIT);
    assign w_nextState = nextState(r_state, bus.op, bus.mem_ready, w_timeout);
    // Every way into HALT (illegal opcode, timeout, corrupt state) is a fault.
    assign w_setFault  = (w_nextState == ST_HALT) && (r_state != ST_HALT);

    // State register plus the registered Moore control word. The control
    // word is loaded from the next state so it always matches r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_ctrl    <= decodeState(ST_FETCH);
            r_fault   <= 1'b0;
            r_waitCnt <= '0;
        end else begin
            r_state <= w_nextState;
            r_ctrl  <= decodeState(w_nextState);
            if (w_setFault) r_fault <= 1'b1;
            if (TIMEOUT_ON && r_ctrl.memReq && !bus.mem_ready && !w_timeout)
                r_waitCnt <= r_waitCnt + 1'b1;
            else
                r_waitCnt <= '0;
        end
    end

    // Fetch handshake completes combinationally with mem_ready. rst_n gates
    // the request so it drops the instant reset is asserted mid-access.
    assign w_fetchDone   = rst_n && (r_state == ST_FETCH) && bus.mem_ready;

    assign bus.mem_req   = rst_n && r_ctrl.memReq;
    assign bus.MemWrite  = r_ctrl.memWrite;
    assign bus.AdrSrc    = r_ctrl.adrSrc;
    assign bus.IRWrite   = w_fetchDone;
    assign bus.PCUpdate  = r_ctrl.pcUpdate | w_fetchDone;
    assign bus.Branch    = r_ctrl.branch;
    assign bus.RegWrite  = r_ctrl.regWrite;
    assign bus.ALUSrcA   = r_ctrl.aluSrcA;
    assign bus.ALUSrcB   = r_ctrl.aluSrcB;
    assign bus.ALUOp     = r_ctrl.aluOp;
    assign bus.ResultSrc = r_ctrl.resultSrc;
    assign bus.fault     = r_fault;
    assign bus.state_o   = r_state;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_cycleCnt;
    logic [CNT_W-1:0] r_instretCnt;
    logic             w_retire;

    // An instruction retires on the step back to FETCH from its final state.
    assign w_retire = (w_nextState == ST_FETCH) &&
                      ((r_state == ST_MEMWB) || (r_state == ST_MEMWRITE) ||
                       (r_state == ST_ALUWB) || (r_state == ST_BEQ));

    // Free-running performance counters; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycleCnt   <= '0;
            r_instretCnt <= '0;
        end else begin
            if (r_state != ST_HALT) r_cycleCnt <= r_cycleCnt + 1'b1;
            if (w_retire) r_instretCnt <= r_instretCnt + 1'b1;
        end
    end

    assign cycle_cnt   = r_cycleCnt;
    assign instret_cnt = r_instretCnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Self-checking bench for multicycle_ctrl_fsm. Stimulus walks whole
// instructions (with chosen memory wait counts) and queues the expected
// per-cycle controller behaviour; a monitor on the falling edge pops and
// compares. Covers reset, every instruction class, illegal opcodes, the
// memory timeout and its mem_ready-on-the-limit boundary, and reset asserted
// mid-access. Counter checks are compiled in when PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    localparam int TB_TIMEOUT = 4;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                   S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7,
                   S_ALUWB = 8, S_BEQ = 9, S_JAL = 10, S_HALT = 15;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic [3:0] state;
        logic       memReq, memWrite, irWrite, pcUpdate, branch, regWrite, fault;
        logic       careAdr;
        logic       adrSrc;
        logic       careSel;
        logic [1:0] aluSrcA, aluSrcB, aluOp;
        logic       careRes;
        logic [1:0] resultSrc;
    } exp_t;

    logic clk;
    logic rst_n;
    multicycle_ctrl_fsm_if bus();

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PERF_CNT_EN
        , .cycle_cnt   (cycle_cnt)
        , .instret_cnt (instret_cnt)
`endif
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t expQ[$];
    exp_t monE;
    logic expFault   = 1'b0;
    int   expCycle   = 0;
    int   expInstret = 0;

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Expected controller outputs for one cycle, taken from the state table.
    function automatic exp_t expFor(input int st, input logic rdy, input logic flt);
        exp_t e;
        e       = '0;
        e.state = 4'(st);
        e.fault = flt;
        case (st)
            S_FETCH: begin
                e.memReq = 1; e.careAdr = 1; e.adrSrc = 0;
                e.careSel = 1; e.aluSrcA = 2'b00; e.aluSrcB = 2'b10; e.aluOp = 2'b00;
                e.careRes = 1; e.resultSrc = 2'b10;
                e.irWrite = rdy; e.pcUpdate = rdy;
            end
            S_DECODE:   begin e.careSel = 1; e.aluSrcA = 2'b01; e.aluSrcB = 2'b01; e.aluOp = 2'b00; end
            S_MEMADR:   begin e.careSel = 1; e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; e.aluOp = 2'b00; end
            S_MEMREAD:  begin e.memReq = 1; e.careAdr = 1; e.adrSrc = 1; end
            S_MEMWB:    begin e.careRes = 1; e.resultSrc = 2'b01; e.regWrite = 1; end
            S_MEMWRITE: begin e.memReq = 1; e.memWrite = 1; e.careAdr = 1; e.adrSrc = 1; end
            S_EXECR:    begin e.careSel = 1; e.aluSrcA = 2'b10; e.aluSrcB = 2'b00; e.aluOp = 2'b10; end
            S_EXECI:    begin e.careSel = 1; e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; e.aluOp = 2'b10; end
            S_ALUWB:    begin e.careRes = 1; e.resultSrc = 2'b00; e.regWrite = 1; end
            S_BEQ: begin
                e.careSel = 1; e.aluSrcA = 2'b10; e.aluSrcB = 2'b00; e.aluOp = 2'b01;
                e.careRes = 1; e.resultSrc = 2'b00; e.branch = 1;
            end
            S_JAL: begin
                e.careSel = 1; e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.aluOp = 2'b00;
                e.careRes = 1; e.resultSrc = 2'b00; e.pcUpdate = 1;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    // Monitor: every falling edge with a pending expectation is compared.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            checkOutput("state_o",  32'(bus.state_o),  32'(monE.state));
            checkOutput("mem_req",  32'(bus.mem_req),  32'(monE.memReq));
            checkOutput("MemWrite", 32'(bus.MemWrite), 32'(monE.memWrite));
            checkOutput("IRWrite",  32'(bus.IRWrite),  32'(monE.irWrite));
            checkOutput("PCUpdate", 32'(bus.PCUpdate), 32'(monE.pcUpdate));
            checkOutput("Branch",   32'(bus.Branch),   32'(monE.branch));
            checkOutput("RegWrite", 32'(bus.RegWrite), 32'(monE.regWrite));
            checkOutput("fault",    32'(bus.fault),    32'(monE.fault));
            if (monE.careAdr) checkOutput("AdrSrc", 32'(bus.AdrSrc), 32'(monE.adrSrc));
            if (monE.careSel) begin
                checkOutput("ALUSrcA", 32'(bus.ALUSrcA), 32'(monE.aluSrcA));
                checkOutput("ALUSrcB", 32'(bus.ALUSrcB), 32'(monE.aluSrcB));
                checkOutput("ALUOp",   32'(bus.ALUOp),   32'(monE.aluOp));
            end
            if (monE.careRes) checkOutput("ResultSrc", 32'(bus.ResultSrc), 32'(monE.resultSrc));
        end
    end

    // One controller cycle: drive mem_ready, queue the expectation, advance.
    task automatic driveCycle(input int st, input logic rdy);
        bus.mem_ready = rdy;
        expQ.push_back(expFor(st, rdy, expFault));
        if (st != S_HALT) expCycle++;
        @(posedge clk);
        #1;
    endtask

    task automatic haltCycles(input int n);
        for (int i = 0; i < n; i++) driveCycle(S_HALT, rnd());
    endtask

    task automatic checkCounters(input string tag);
`ifdef PERF_CNT_EN
        checkOutput({tag, "_cycle_cnt"},   cycle_cnt,   32'(expCycle));
        checkOutput({tag, "_instret_cnt"}, instret_cnt, 32'(expInstret));
`else
        if (tag.len() < 0) $display("[TB] %s", tag);
`endif
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_state"},     32'(bus.state_o),   32'(S_FETCH));
        checkOutput({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
        checkOutput({tag, "_MemWrite"},  32'(bus.MemWrite),  32'd0);
        checkOutput({tag, "_IRWrite"},   32'(bus.IRWrite),   32'd0);
        checkOutput({tag, "_PCUpdate"},  32'(bus.PCUpdate),  32'd0);
        checkOutput({tag, "_Branch"},    32'(bus.Branch),    32'd0);
        checkOutput({tag, "_RegWrite"},  32'(bus.RegWrite),  32'd0);
        checkOutput({tag, "_ALUOp"},     32'(bus.ALUOp),     32'd0);
        checkOutput({tag, "_ALUSrcA"},   32'(bus.ALUSrcA),   32'd0);
        checkOutput({tag, "_ALUSrcB"},   32'(bus.ALUSrcB),   32'd2);
        checkOutput({tag, "_ResultSrc"}, 32'(bus.ResultSrc), 32'd2);
        checkOutput({tag, "_fault"},     32'(bus.fault),     32'd0);
        expCycle   = 0;
        expInstret = 0;
        checkCounters(tag);
        expFault = 1'b0;
    endtask

    // Called at posedge+1 (or at time 1): hold reset for a cycle with
    // mem_ready high to show the fetch pulses stay gated off.
    task automatic doReset();
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.op        = 7'($urandom);
        #3;
        checkReset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Run one whole instruction. fw/mw are wait cycles before mem_ready in
    // the fetch and data-memory phases (kept below the timeout limit).
    task automatic applyStimulus(input logic [6:0] opc, input int fw, input int mw);
        bit legal;
        legal  = 1'b1;
        bus.op = opc;
        for (int i = 0; i < fw; i++) driveCycle(S_FETCH, 1'b0);
        driveCycle(S_FETCH, 1'b1);
        driveCycle(S_DECODE, rnd());
        case (opc)
            OP_LW: begin
                driveCycle(S_MEMADR, rnd());
                for (int i = 0; i < mw; i++) driveCycle(S_MEMREAD, 1'b0);
                driveCycle(S_MEMREAD, 1'b1);
                driveCycle(S_MEMWB, rnd());
            end
            OP_SW: begin
                driveCycle(S_MEMADR, rnd());
                for (int i = 0; i < mw; i++) driveCycle(S_MEMWRITE, 1'b0);
                driveCycle(S_MEMWRITE, 1'b1);
            end
            OP_R:   begin driveCycle(S_EXECR, rnd()); driveCycle(S_ALUWB, rnd()); end
            OP_I:   begin driveCycle(S_EXECI, rnd()); driveCycle(S_ALUWB, rnd()); end
            OP_BEQ: driveCycle(S_BEQ, rnd());
            OP_JAL: begin driveCycle(S_JAL, rnd()); driveCycle(S_ALUWB, rnd()); end
            default: begin
                legal    = 1'b0;
                expFault = 1'b1;
                haltCycles(3);
            end
        endcase
        if (legal) expInstret++;
        checkCounters("instr");
    endtask

    // Let mem_ready stay low for the full limit in fetch or the data phase.
    task automatic applyTimeout(input logic [6:0] opc, input bit inFetch);
        bus.op = opc;
        if (inFetch) begin
            for (int i = 0; i < TB_TIMEOUT; i++) driveCycle(S_FETCH, 1'b0);
        end else begin
            driveCycle(S_FETCH, 1'b1);
            driveCycle(S_DECODE, rnd());
            driveCycle(S_MEMADR, rnd());
            for (int i = 0; i < TB_TIMEOUT; i++)
                driveCycle((opc == OP_LW) ? S_MEMREAD : S_MEMWRITE, 1'b0);
        end
        expFault = 1'b1;
        haltCycles(3);
        checkCounters("timeout");
    endtask

    // Assert reset partway through a stalled load read.
    task automatic applyResetMidRead();
        bus.op = OP_LW;
        driveCycle(S_FETCH, 1'b1);
        driveCycle(S_DECODE, 1'b1);
        driveCycle(S_MEMADR, 1'b0);
        driveCycle(S_MEMREAD, 1'b0);
        driveCycle(S_MEMREAD, 1'b0);
        bus.mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("midread");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] legalOps [6];
        legalOps[0] = OP_LW; legalOps[1] = OP_SW; legalOps[2] = OP_R;
        legalOps[3] = OP_I;  legalOps[4] = OP_BEQ; legalOps[5] = OP_JAL;

        rst_n         = 1'b1;
        bus.op        = 7'd0;
        bus.mem_ready = 1'b0;
        #1;
        doReset();

        // Three back-to-back addi with zero-wait memory.
        for (int i = 0; i < 3; i++) applyStimulus(OP_I, 0, 0);
        applyStimulus(OP_R, 0, 0);
        applyStimulus(OP_LW, 0, 3);
        applyStimulus(OP_BEQ, 0, 0);
        applyStimulus(OP_SW, 2, 1);
        applyStimulus(OP_JAL, 1, 0);
        // mem_ready arriving on the limit cycle must not fault.
        applyStimulus(OP_R, TB_TIMEOUT - 1, 0);
        applyStimulus(OP_LW, 0, TB_TIMEOUT - 1);
        applyStimulus(OP_SW, 0, TB_TIMEOUT - 1);

        for (int n = 0; n < 60; n++) begin
            int fw, mw;
            fw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, TB_TIMEOUT - 1));
            mw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, TB_TIMEOUT - 1));
            applyStimulus(legalOps[$urandom_range(0, 5)], fw, mw);
        end

        applyStimulus(7'b1111111, 0, 0);
        doReset();
        applyStimulus(7'b0110111, 1, 0);
        doReset();

        applyTimeout(OP_R, 1'b1);
        doReset();
        applyTimeout(OP_LW, 1'b0);
        doReset();
        applyTimeout(OP_SW, 1'b0);
        doReset();

        applyResetMidRead();
        applyStimulus(OP_R, 0, 0);

        @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net in case the run ever stops advancing.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
